// File: rtl/fft_stage_sequencer.sv
// ============================================================================
// fft_stage_sequencer
// ----------------------------------------------------------------------------
// Control sequencer for an in-place radix-2 decimation-in-time FFT. A
// transform runs in four phases:
//    1. The external bit-reversal reorder is launched, and the sequencer waits
//       for it to complete.
//    2. For each stage s, all N/2 butterfly commands are issued through a
//       valid/ready handshake. Each command carries the operand addresses and
//       the twiddle ROM address.
//    3. The sequencer waits until every issued butterfly has reported its
//       writeback, so the next stage never reads stale data.
//    4. A one-cycle done pulse is raised after the last stage.
//
// Parameters
//    N       FFT points, power of two in 4..256
//    STAGES  radix-2 stage count, $clog2(N); address width AW = STAGES
//
// Ports
//    clk           rising-edge clock
//    rst_n         asynchronous active-low reset
//    start         transform request, accepted only while idle
//    bitrev_start  one-cycle pulse that launches the bit-reversal reorder
//    bitrev_done   reorder finished, sampled only while waiting for it
//    bf_valid      butterfly command valid
//    bf_ready      butterfly datapath accepts the command
//    bf_idx_a      upper operand address (AW bits)
//    bf_idx_b      lower operand address (AW bits)
//    bf_tw_addr    twiddle ROM address (AW-1 bits)
//    bf_stage      current stage index ($clog2(STAGES) bits)
//    bf_last       final command of the final stage
//    bf_wb         one pulse per completed butterfly writeback
//    busy          transform in progress
//    done          one-cycle completion pulse
//    err           sticky protocol error (writeback with nothing outstanding)
//    cycle_cnt     busy-cycle count of the latest transform
//
// Optional feature
//    FFT_SEQ_CYCLE_CNT_EN  when defined, cycle_cnt counts busy cycles. The
//                          count clears when a start is accepted and saturates
//                          at 16'hFFFF. When the macro is undefined, cycle_cnt
//                          is tied to zero.
// ============================================================================
module fft_stage_sequencer #(
   parameter  int N      = 256,
   parameter  int STAGES = $clog2(N),
   localparam int AW     = STAGES,
   localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          bitrev_start,
   input  logic          bitrev_done,
   output logic          bf_valid,
   input  logic          bf_ready,
   output logic [AW-1:0] bf_idx_a,
   output logic [AW-1:0] bf_idx_b,
   output logic [AW-2:0] bf_tw_addr,
   output logic [SW-1:0] bf_stage,
   output logic          bf_last,
   input  logic          bf_wb,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [15:0]   cycle_cnt
);

   // The butterfly index k runs over 0..N/2-1, so it needs one bit fewer than
   // a point address.
   localparam int KW = AW - 1;
   localparam logic [KW-1:0] LAST_K = KW'(N / 2 - 1);
   localparam logic [SW-1:0] LAST_S = SW'(STAGES - 1);

   typedef enum logic [2:0] {
      IDLE,
      BITREV,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] s_q, s_d;
   logic [KW-1:0] k_q, k_d;
   logic [AW-1:0] out_q, out_d;
   logic          err_d;
   logic          hs;
   logic          wb_ok;
   logic          issue_d;
   logic          busy_d;

   int            sh;
   logic [AW-1:0] kx;
   logic [AW-1:0] half;
   logic [AW-1:0] pos;
   logic [AW-1:0] a_d;
   logic [AW-1:0] b_d;
   logic [AW-2:0] tw_d;

   // Next-state logic for the phase FSM, the stage and butterfly counters,
   // and the outstanding-writeback counter.
   //
   // The outstanding counter holds at most N/2 within a stage, so AW bits are
   // enough. A writeback that arrives when nothing is outstanding is a
   // protocol error. Such a writeback is flagged in err and otherwise
   // ignored, so it can never move the FSM. Accepting a new start clears
   // every piece of per-transform state, including the sticky error.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      out_d   = out_q;
      err_d   = err;
      hs      = (state_q == ISSUE) && bf_ready;
      wb_ok   = bf_wb && (out_q != '0);

      if (bf_wb && (out_q == '0)) begin
         err_d = 1'b1;
      end

      if (hs && !wb_ok) begin
         out_d = out_q + AW'(1);
      end else if (!hs && wb_ok) begin
         out_d = out_q - AW'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BITREV;
               s_d     = '0;
               k_d     = '0;
               out_d   = '0;
               err_d   = 1'b0;
            end
         end
         BITREV: begin
            if (bitrev_done) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (hs) begin
               if (k_q == LAST_K) begin
                  k_d     = '0;
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         DRAIN: begin
            if (out_q == '0) begin
               if (s_q == LAST_S) begin
                  state_d = DONE;
               end else begin
                  s_d     = s_q + SW'(1);
                  state_d = ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Butterfly addressing for the next command, derived from the next (s, k).
   //
   // Within stage s, butterflies form groups of 2*half points with
   // half = 2^s. Butterfly k lies in group k>>s at offset pos inside the
   // group, and its partner is half points further on. The twiddle index
   // steps by N/(2*half), which is pos shifted left by STAGES-1-s.
   always_comb begin
      sh   = int'(s_d);
      kx   = {1'b0, k_d};
      half = AW'(1) << sh;
      pos  = kx & (half - AW'(1));
      a_d  = ((kx >> sh) << (sh + 1)) + pos;
      b_d  = a_d + half;
      tw_d = pos[AW-2:0] << (STAGES - 1 - sh);
   end

   assign issue_d = (state_d == ISSUE);
   assign busy_d  = (state_d == BITREV) || (state_d == ISSUE) || (state_d == DRAIN);

   // State and counter registers, together with the registered outputs.
   //
   // Every output is computed from the next state, so each output changes
   // on the same edge as the state it belongs to. Outside ISSUE, the command
   // buses are forced to zero. While a command is stalled, (s, k) do not
   // change, so the command buses stay stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         s_q          <= '0;
         k_q          <= '0;
         out_q        <= '0;
         err          <= 1'b0;
         bitrev_start <= 1'b0;
         bf_valid     <= 1'b0;
         bf_idx_a     <= '0;
         bf_idx_b     <= '0;
         bf_tw_addr   <= '0;
         bf_stage     <= '0;
         bf_last      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         k_q          <= k_d;
         out_q        <= out_d;
         err          <= err_d;
         bitrev_start <= (state_q == IDLE) && start;
         bf_valid     <= issue_d;
         bf_idx_a     <= issue_d ? a_d : '0;
         bf_idx_b     <= issue_d ? b_d : '0;
         bf_tw_addr   <= issue_d ? tw_d : '0;
         bf_stage     <= issue_d ? s_d : '0;
         bf_last      <= issue_d && (s_d == LAST_S) && (k_d == LAST_K);
         busy         <= busy_d;
         done         <= (state_d == DONE);
      end
   end

`ifdef FFT_SEQ_CYCLE_CNT_EN
   logic [15:0] cnt_q;

   // Busy-cycle counter. It clears when a start is accepted and counts every
   // cycle in which busy is high. After a transform completes, the count
   // stays readable until the next start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         cnt_q <= '0;
      end else if (busy && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign cycle_cnt = cnt_q;
`else
   assign cycle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ============================================================================
// tb_fft_stage_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for fft_stage_sequencer with N=256.
//
// A reference list of butterfly commands is built for every stage, in plain
// integer arithmetic (group/offset division). Each command the DUT presents
// is compared against the head of that list. Writebacks return two cycles
// after each handshake, and bf_ready is either held high or randomised.
// ============================================================================
module tb_fft_stage_sequencer;

   localparam int N           = 256;
   localparam int STAGES      = $clog2(N);
   localparam int AW          = STAGES;
   localparam int SW          = $clog2(STAGES);
   localparam int TOTAL       = STAGES * N / 2;
   localparam int CYCLE_LIMIT = 8000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          bitrev_start;
   logic          bitrev_done;
   logic          bf_valid;
   logic          bf_ready;
   logic [AW-1:0] bf_idx_a;
   logic [AW-1:0] bf_idx_b;
   logic [AW-2:0] bf_tw_addr;
   logic [SW-1:0] bf_stage;
   logic          bf_last;
   logic          bf_wb;
   logic          busy;
   logic          done;
   logic          err;
   logic [15:0]   cycle_cnt;

   typedef struct {
      int s;
      int a;
      int b;
      int tw;
      bit last;
   } cmd_t;

   cmd_t exp_q[$];

   int checks = 0;
   int passed = 0;

   int obs_hs, obs_bad, obs_left, obs_last, obs_done, obs_busy, obs_brs;
   int obs_brs_first, obs_first_valid, obs_err, obs_timeout, obs_stopped;
   int obs_cnt, gap, exp_cnt;
   int cap_a  [TOTAL];
   int cap_b  [TOTAL];
   int cap_tw [TOTAL];

   always #5 clk = ~clk;

   fft_stage_sequencer #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bitrev_start (bitrev_start),
      .bitrev_done  (bitrev_done),
      .bf_valid     (bf_valid),
      .bf_ready     (bf_ready),
      .bf_idx_a     (bf_idx_a),
      .bf_idx_b     (bf_idx_b),
      .bf_tw_addr   (bf_tw_addr),
      .bf_stage     (bf_stage),
      .bf_last      (bf_last),
      .bf_wb        (bf_wb),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .cycle_cnt    (cycle_cnt)
   );

   // Runs one transform: start, reorder handshake, command issue, and
   // writebacks returned two cycles after each handshake. If stop_stage is
   // non-negative, the run stops at the first valid command of that stage.
   task automatic run_sequence(input bit rand_ready, input int stop_stage);
      cmd_t     c;
      bit [1:0] pipe;
      bit       hs;
      bit       fin;
      exp_q.delete();
      for (int s = 0; s < STAGES; s++) begin
         for (int k = 0; k < N / 2; k++) begin
            int half;
            int pos;
            half   = 2 ** s;
            pos    = k % half;
            c.s    = s;
            c.a    = (k / half) * 2 * half + pos;
            c.b    = c.a + half;
            c.tw   = pos * (N / (2 * half));
            c.last = (s == STAGES - 1) && (k == N / 2 - 1);
            exp_q.push_back(c);
         end
      end
      obs_hs = 0; obs_bad = 0; obs_last = 0; obs_done = 0; obs_busy = 0;
      obs_brs = 0; obs_brs_first = 0; obs_first_valid = -1; obs_err = 0;
      obs_timeout = 0; obs_stopped = 0; obs_cnt = -1;
      gap  = $urandom_range(2, 5);
      pipe = 2'b00;
      fin  = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 0; cyc < CYCLE_LIMIT && !fin; cyc++) begin
         @(negedge clk);
         start = (cyc == 1);
         if (cyc == 0) obs_brs_first = int'(bitrev_start);
         if (bitrev_start === 1'b1) obs_brs++;
         if (busy === 1'b1) obs_busy++;
         if (err !== 1'b0) obs_err++;
         bitrev_done = (cyc == gap);
         bf_wb       = pipe[1];
         bf_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         hs          = (bf_valid === 1'b1) && bf_ready;
         if (bf_valid === 1'b1) begin
            if (obs_first_valid < 0) obs_first_valid = cyc;
            if (exp_q.size() == 0) begin
               obs_bad++;
            end else if (int'(bf_stage) != exp_q[0].s || int'(bf_idx_a) != exp_q[0].a ||
                         int'(bf_idx_b) != exp_q[0].b || int'(bf_tw_addr) != exp_q[0].tw ||
                         bf_last !== exp_q[0].last) begin
               obs_bad++;
               if (obs_bad <= 3)
                  $display("[TB] command deviation at handshake %0d: stage %0d a %0d b %0d tw %0d last %b (model s %0d a %0d b %0d tw %0d last %b)",
                           obs_hs, bf_stage, bf_idx_a, bf_idx_b, bf_tw_addr, bf_last,
                           exp_q[0].s, exp_q[0].a, exp_q[0].b, exp_q[0].tw, exp_q[0].last);
            end
         end else if (bf_last !== 1'b0) begin
            obs_bad++;
         end
         if (hs) begin
            if (obs_hs < TOTAL) begin
               cap_a[obs_hs]  = int'(bf_idx_a);
               cap_b[obs_hs]  = int'(bf_idx_b);
               cap_tw[obs_hs] = int'(bf_tw_addr);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            obs_hs++;
            if (bf_last === 1'b1) obs_last++;
         end
         pipe = {pipe[0], hs};
         if (done === 1'b1) begin
            obs_done++;
            obs_cnt = int'(cycle_cnt);
            fin     = 1'b1;
         end
         if (stop_stage >= 0 && bf_valid === 1'b1 && int'(bf_stage) == stop_stage) begin
            obs_stopped = 1;
            fin         = 1'b1;
         end
      end
      if (!fin) obs_timeout = 1;
      obs_left    = exp_q.size();
      start       = 1'b0;
      bitrev_done = 1'b0;
      bf_ready    = 1'b0;
      bf_wb       = 1'b0;
`ifdef FFT_SEQ_CYCLE_CNT_EN
      exp_cnt = (obs_busy > 65535) ? 65535 : obs_busy;
`else
      exp_cnt = 0;
`endif
   endtask

   // Power-on reset: every output must be zero while rst_n is low.
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bitrev_done = 1'b0; bf_ready = 1'b0; bf_wb = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
      checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passed++;
      checks++; if (bf_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bf_valid); else passed++;
      checks++; if (bitrev_start !== 1'b0) $display("[TB] FAIL reset_bitrev_start: got %b expected 0", bitrev_start); else passed++;
      checks++; if ({bf_idx_a, bf_idx_b, bf_tw_addr, bf_stage, bf_last} !== '0) $display("[TB] FAIL reset_cmd_bus: got %h expected 0", {bf_idx_a, bf_idx_b, bf_tw_addr, bf_stage, bf_last}); else passed++;
      checks++; if (cycle_cnt !== 16'h0000) $display("[TB] FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Full transform with bf_ready held high. A spurious start is issued while busy.
   task automatic test_full_ready();
      run_sequence(1'b0, -1);
      checks++; if (obs_timeout !== 0) $display("[TB] FAIL full_timeout: got %0d expected 0", obs_timeout); else passed++;
      checks++; if (obs_brs_first !== 1) $display("[TB] FAIL full_bitrev_first: got %0d expected 1", obs_brs_first); else passed++;
      checks++; if (obs_brs !== 1) $display("[TB] FAIL full_bitrev_count: got %0d expected 1", obs_brs); else passed++;
      checks++; if (obs_first_valid !== gap + 1) $display("[TB] FAIL full_first_valid: got %0d expected %0d", obs_first_valid, gap + 1); else passed++;
      checks++; if (obs_hs !== TOTAL) $display("[TB] FAIL full_handshakes: got %0d expected %0d", obs_hs, TOTAL); else passed++;
      checks++; if (obs_bad !== 0) $display("[TB] FAIL full_cmd_deviations: got %0d expected 0", obs_bad); else passed++;
      checks++; if (obs_left !== 0) $display("[TB] FAIL full_cmds_left: got %0d expected 0", obs_left); else passed++;
      checks++; if (obs_last !== 1) $display("[TB] FAIL full_last_count: got %0d expected 1", obs_last); else passed++;
      checks++; if (obs_done !== 1) $display("[TB] FAIL full_done_count: got %0d expected 1", obs_done); else passed++;
      checks++; if (obs_err !== 0) $display("[TB] FAIL full_err_cycles: got %0d expected 0", obs_err); else passed++;
      checks++; if (obs_cnt !== exp_cnt) $display("[TB] FAIL full_cycle_cnt: got %0d expected %0d", obs_cnt, exp_cnt); else passed++;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("[TB] FAIL full_done_width: got %b expected 0", done); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL full_idle_busy: got %b expected 0", busy); else passed++;
      checks++; if (int'(cycle_cnt) !== exp_cnt) $display("[TB] FAIL full_cnt_hold: got %0d expected %0d", cycle_cnt, exp_cnt); else passed++;
   endtask

   // Known address points captured from the preceding transform (index = s*N/2 + k).
   task automatic test_addressing();
      checks++; if (cap_a[0] !== 0) $display("[TB] FAIL addr_s0k0_a: got %0d expected 0", cap_a[0]); else passed++;
      checks++; if (cap_b[0] !== 1) $display("[TB] FAIL addr_s0k0_b: got %0d expected 1", cap_b[0]); else passed++;
      checks++; if (cap_tw[0] !== 0) $display("[TB] FAIL addr_s0k0_tw: got %0d expected 0", cap_tw[0]); else passed++;
      checks++; if (cap_a[261] !== 9) $display("[TB] FAIL addr_s2k5_a: got %0d expected 9", cap_a[261]); else passed++;
      checks++; if (cap_b[261] !== 13) $display("[TB] FAIL addr_s2k5_b: got %0d expected 13", cap_b[261]); else passed++;
      checks++; if (cap_tw[261] !== 32) $display("[TB] FAIL addr_s2k5_tw: got %0d expected 32", cap_tw[261]); else passed++;
      checks++; if (cap_a[901] !== 5) $display("[TB] FAIL addr_s7k5_a: got %0d expected 5", cap_a[901]); else passed++;
      checks++; if (cap_b[901] !== 133) $display("[TB] FAIL addr_s7k5_b: got %0d expected 133", cap_b[901]); else passed++;
      checks++; if (cap_tw[901] !== 5) $display("[TB] FAIL addr_s7k5_tw: got %0d expected 5", cap_tw[901]); else passed++;
   endtask

   // Randomly stalled datapath: no skipped, duplicated or drifting commands.
   task automatic test_random_ready();
      run_sequence(1'b1, -1);
      checks++; if (obs_timeout !== 0) $display("[TB] FAIL rand_timeout: got %0d expected 0", obs_timeout); else passed++;
      checks++; if (obs_hs !== TOTAL) $display("[TB] FAIL rand_handshakes: got %0d expected %0d", obs_hs, TOTAL); else passed++;
      checks++; if (obs_bad !== 0) $display("[TB] FAIL rand_cmd_deviations: got %0d expected 0", obs_bad); else passed++;
      checks++; if (obs_left !== 0) $display("[TB] FAIL rand_cmds_left: got %0d expected 0", obs_left); else passed++;
      checks++; if (obs_last !== 1) $display("[TB] FAIL rand_last_count: got %0d expected 1", obs_last); else passed++;
      checks++; if (obs_done !== 1) $display("[TB] FAIL rand_done_count: got %0d expected 1", obs_done); else passed++;
      checks++; if (obs_err !== 0) $display("[TB] FAIL rand_err_cycles: got %0d expected 0", obs_err); else passed++;
      checks++; if (obs_cnt !== exp_cnt) $display("[TB] FAIL rand_cycle_cnt: got %0d expected %0d", obs_cnt, exp_cnt); else passed++;
      @(negedge clk);
   endtask

   // Stray bitrev_done and bf_wb in IDLE. err is sticky until the next start.
   task automatic test_spurious_wb();
      @(negedge clk);
      bitrev_done = 1'b1;
      @(negedge clk);
      bitrev_done = 1'b0;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL spur_bitrev_busy: got %b expected 0", busy); else passed++;
      bf_wb = 1'b1;
      @(negedge clk);
      bf_wb = 1'b0;
      checks++; if (err !== 1'b1) $display("[TB] FAIL spur_err_set: got %b expected 1", err); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL spur_busy: got %b expected 0", busy); else passed++;
      checks++; if (bf_valid !== 1'b0) $display("[TB] FAIL spur_valid: got %b expected 0", bf_valid); else passed++;
      @(negedge clk);
      checks++; if (err !== 1'b1) $display("[TB] FAIL spur_err_sticky: got %b expected 1", err); else passed++;
      checks++; if (bitrev_start !== 1'b0) $display("[TB] FAIL spur_bitrev_start: got %b expected 0", bitrev_start); else passed++;
      run_sequence(1'b0, -1);
      checks++; if (obs_err !== 0) $display("[TB] FAIL spur_err_cleared: got %0d err cycles expected 0", obs_err); else passed++;
      checks++; if (obs_done !== 1) $display("[TB] FAIL spur_done_count: got %0d expected 1", obs_done); else passed++;
      @(negedge clk);
   endtask

   // Asynchronous reset during stage 3, then a fresh transform from stage 0.
   task automatic test_reset_midway();
      run_sequence(1'b0, 3);
      checks++; if (obs_stopped !== 1) $display("[TB] FAIL mid_reach_stage3: got %0d expected 1", obs_stopped); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b expected 0", busy); else passed++;
      checks++; if (bf_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", bf_valid); else passed++;
      checks++; if (bf_idx_b !== '0) $display("[TB] FAIL mid_idx_b: got %0d expected 0", bf_idx_b); else passed++;
      checks++; if (bf_stage !== '0) $display("[TB] FAIL mid_stage: got %0d expected 0", bf_stage); else passed++;
      checks++; if ({bf_idx_a, bf_tw_addr, bf_last, done, bitrev_start, err} !== '0) $display("[TB] FAIL mid_other_outputs: got %h expected 0", {bf_idx_a, bf_tw_addr, bf_last, done, bitrev_start, err}); else passed++;
      checks++; if (cycle_cnt !== 16'h0000) $display("[TB] FAIL mid_cycle_cnt: got %0d expected 0", cycle_cnt); else passed++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (done !== 1'b0) $display("[TB] FAIL mid_no_done: got %b expected 0", done); else passed++;
      run_sequence(1'b0, -1);
      checks++; if (obs_timeout !== 0) $display("[TB] FAIL mid_timeout: got %0d expected 0", obs_timeout); else passed++;
      checks++; if (obs_hs !== TOTAL) $display("[TB] FAIL mid_handshakes: got %0d expected %0d", obs_hs, TOTAL); else passed++;
      checks++; if (obs_bad !== 0) $display("[TB] FAIL mid_cmd_deviations: got %0d expected 0", obs_bad); else passed++;
      checks++; if (obs_done !== 1) $display("[TB] FAIL mid_done_count: got %0d expected 1", obs_done); else passed++;
      checks++; if (obs_cnt !== exp_cnt) $display("[TB] FAIL mid_cycle_cnt_after: got %0d expected %0d", obs_cnt, exp_cnt); else passed++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_ready();
      test_addressing();
      test_random_ready();
      test_spurious_wb();
      test_reset_midway();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
